// File: rtl/sbus_mem_slave.sv
// -----------------------------------------------------------------------------
// sbus_mem_slave
//
// Simple bus slave fronting a 256x8 storage array. A master raises req, is
// granted the bus, then issues single-cycle start commands. Each beat spends
// WAIT_CYCLES wait states followed by one ACCESS cycle, which carries the rdy
// completion pulse.
//
// Optional feature: define SBUS_BURST_EN to make mode 10 a 4-beat
// incrementing burst read (address wraps modulo 256). Without it, mode 10 is
// a plain single read.
//
// Parameters
//   WAIT_CYCLES  wait states per beat, 0..7 (default 1)
//
// Ports
//   clk    in   1  bus clock, rising edge
//   rst    in   1  asynchronous active-high reset
//   req    in   1  master requests the bus
//   gnt    out  1  bus granted (GRANT/WAIT/ACCESS)
//   start  in   1  transfer command, sampled only in GRANT
//   mode   in   2  00 read, 01 write, 10 burst read, 11 reserved
//   addr   in   8  byte address
//   wdata  in   8  write data
//   rdata  out  8  read data, valid while rdy=1, held otherwise
//   rdy    out  1  one-cycle completion pulse per beat
//   err    out  1  with rdy: reserved mode, nothing accessed
// -----------------------------------------------------------------------------
module sbus_mem_slave #(
   parameter int WAIT_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req,
   output logic       gnt,
   input  logic       start,
   input  logic [1:0] mode,
   input  logic [7:0] addr,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       rdy,
   output logic       err
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT  = 2'd1,
      WAIT   = 2'd2,
      ACCESS = 2'd3
   } state_t;

   localparam logic [1:0] M_READ  = 2'b00;
   localparam logic [1:0] M_WRITE = 2'b01;
   localparam logic [1:0] M_BURST = 2'b10;
   localparam logic [1:0] M_RSVD  = 2'b11;

   // Last value of the wait counter before moving on to ACCESS.
   localparam logic [2:0] WAIT_LAST = (WAIT_CYCLES == 0) ? 3'd0 : 3'(WAIT_CYCLES - 1);
   // First state of every beat: straight to ACCESS when there are no wait states.
   localparam state_t BEAT_ENTRY = (WAIT_CYCLES == 0) ? ACCESS : WAIT;

   state_t      state;
   state_t      state_nxt;
   logic [2:0]  wait_cnt;
   logic [1:0]  cap_mode;
   logic [7:0]  cap_addr;
   logic [7:0]  cap_wdata;
   logic        burst_more;
   logic [1:0]  rd_mode;
   logic [7:0]  rd_addr;
   logic        rd_load;

   logic [7:0]  mem [256];

`ifdef SBUS_BURST_EN
   logic [1:0]  beat;

   // Another burst beat follows the current ACCESS cycle.
   assign burst_more = (cap_mode == M_BURST) && (beat != 2'd3);
`else
   assign burst_more = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and bus outputs
   always_comb begin
      state_nxt = state;
      gnt       = 1'b0;
      rdy       = 1'b0;
      err       = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               state_nxt = GRANT;
            end
         end
         GRANT: begin
            gnt = 1'b1;
            if (!req) begin
               state_nxt = IDLE;
            end else if (start) begin
               state_nxt = BEAT_ENTRY;
            end
         end
         WAIT: begin
            gnt = 1'b1;
            if (wait_cnt == WAIT_LAST) begin
               state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            gnt = 1'b1;
            rdy = 1'b1;
            err = (cap_mode == M_RSVD);
            // req is only consulted once the whole transfer is done.
            if (burst_more) begin
               state_nxt = BEAT_ENTRY;
            end else if (req) begin
               state_nxt = GRANT;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Wait counter restarts from zero every time WAIT is entered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= 3'd0;
      end else if (state == WAIT) begin
         wait_cnt <= wait_cnt + 3'd1;
      end else begin
         wait_cnt <= 3'd0;
      end
   end

   // Command capture on an accepted start
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cap_mode  <= 2'b00;
         cap_addr  <= 8'h00;
         cap_wdata <= 8'h00;
      end else if ((state == GRANT) && req && start) begin
         cap_mode  <= mode;
         cap_addr  <= addr;
         cap_wdata <= wdata;
      end
   end

`ifdef SBUS_BURST_EN
   // Beat counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat <= 2'd0;
      end else if (state == GRANT) begin
         beat <= 2'd0;
      end else if ((state == ACCESS) && burst_more) begin
         beat <= beat + 2'd1;
      end
   end
`endif

   // The read is issued on the edge that enters ACCESS so rdata is already
   // valid during the rdy cycle. Coming straight from GRANT (no wait states)
   // the command has not been captured yet, so the live inputs are used.
   always_comb begin
      rd_mode = cap_mode;
      rd_addr = cap_addr;
      if (state == GRANT) begin
         rd_mode = mode;
         rd_addr = addr;
      end
`ifdef SBUS_BURST_EN
      else if (state == ACCESS) begin
         rd_addr = cap_addr + {6'd0, beat} + 8'd1;
      end else begin
         rd_addr = cap_addr + {6'd0, beat};
      end
`endif
   end

   assign rd_load = (state_nxt == ACCESS) &&
                    ((rd_mode == M_READ) || (rd_mode == M_BURST));

   // Read data register: only read beats update it, so it holds otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata <= 8'h00;
      end else if (rd_load) begin
         rdata <= mem[rd_addr];
      end
   end

   // Storage array, not reset. A write commits only at the end of ACCESS, so
   // a reset earlier in the transfer leaves the array untouched.
   always_ff @(posedge clk) begin
      if ((state == ACCESS) && (cap_mode == M_WRITE)) begin
         mem[cap_addr] <= cap_wdata;
      end
   end

endmodule

// File: tb/tb_sbus_mem_slave.sv
`timescale 1ns/1ps
module tb_sbus_mem_slave;

   localparam int WC = 1;
`ifdef SBUS_BURST_EN
   localparam int BURST_BEATS = 4;
`else
   localparam int BURST_BEATS = 1;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;

   logic       req, start, gnt, rdy, err;
   logic [1:0] mode;
   logic [7:0] addr, wdata, rdata;

   logic       req0, start0, gnt0, rdy0, err0;
   logic [1:0] mode0;
   logic [7:0] addr0, wdata0, rdata0;

   int         n_tests = 0;
   int         n_fail  = 0;

   logic [7:0] mem_m [256];
   logic [7:0] rd_m;

   always #5 clk = ~clk;

   sbus_mem_slave #(.WAIT_CYCLES(WC)) dut (
      .clk(clk), .rst(rst), .req(req), .gnt(gnt), .start(start), .mode(mode),
      .addr(addr), .wdata(wdata), .rdata(rdata), .rdy(rdy), .err(err)
   );

   sbus_mem_slave #(.WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .req(req0), .gnt(gnt0), .start(start0), .mode(mode0),
      .addr(addr0), .wdata(wdata0), .rdata(rdata0), .rdy(rdy0), .err(err0)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One transfer from GRANT; expectations come from beat arithmetic on the
   // model memory. Called and returns at a falling edge with the bus granted.
   task automatic xfer(input logic [1:0] m, input logic [7:0] a, input logic [7:0] d);
      int   per, nb, total;
      logic last_req;
      per   = WC + 1;
      nb    = (m == 2'b10) ? BURST_BEATS : 1;
      total = nb * per;
      start = 1'b1; mode = m; addr = a; wdata = d; req = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= total; k++) begin
         @(negedge clk);
         if ((k % per) == 0) begin
            int b;
            b = k / per - 1;
            if (m == 2'b00 || m == 2'b10) rd_m = mem_m[8'(int'(a) + b)];
            chk("rdy_beat", 32'(rdy), 32'd1);
            chk("err_beat", 32'(err), 32'(m == 2'b11));
         end else begin
            chk("rdy_wait", 32'(rdy), 32'd0);
            chk("err_wait", 32'(err), 32'd0);
         end
         chk("rdata", 32'(rdata), 32'(rd_m));
         chk("gnt_busy", 32'(gnt), 32'd1);
         if (m == 2'b01 && k == total) mem_m[a] = d;
         // Noise on every input: none of it may disturb the transfer.
         start = 1'($urandom); mode = 2'($urandom); addr = 8'($urandom);
         wdata = 8'($urandom); req = 1'($urandom);
      end
      last_req = req;
      @(negedge clk);
      start = 1'b0;
      chk("gnt_after", 32'(gnt), 32'(last_req));
      chk("rdy_after", 32'(rdy), 32'd0);
      chk("err_after", 32'(err), 32'd0);
      if (!last_req) begin
         req = 1'b1;
         step();
         chk("regrant", 32'(gnt), 32'd1);
      end
   endtask

   // Drop the bus, then re-request with start high in IDLE (must be ignored).
   task automatic idle_gap();
      req = 1'b0; start = 1'($urandom);
      step();
      chk("gap_gnt", 32'(gnt), 32'd0);
      chk("gap_rdy", 32'(rdy), 32'd0);
      req = 1'b1; start = 1'b1;
      step();
      chk("gap_regrant", 32'(gnt), 32'd1);
      start = 1'b0;
      step();
      chk("idle_start_ignored", 32'(rdy), 32'd0);
      chk("gap_rdata", 32'(rdata), 32'(rd_m));
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      req = 0; start = 0; mode = 0; addr = 0; wdata = 0;
      req0 = 0; start0 = 0; mode0 = 0; addr0 = 0; wdata0 = 0;
      rd_m = 8'h00;
      #2 rst = 1'b1;
      @(negedge clk); @(negedge clk);
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_rdy", 32'(rdy), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_rdata", 32'(rdata), 32'd0);
      chk("rst_gnt0", 32'(gnt0), 32'd0);
      rst = 1'b0;

      // Zero wait states, req dropped right after the start edge.
      req0 = 1'b1;
      step();
      chk("w0_gnt", 32'(gnt0), 32'd1);
      start0 = 1'b1; mode0 = 2'b01; addr0 = 8'h05; wdata0 = 8'h3C;
      step();
      start0 = 1'b0; req0 = 1'b0;
      chk("w0_rdy", 32'(rdy0), 32'd1);
      chk("w0_err", 32'(err0), 32'd0);
      chk("w0_gnt_acc", 32'(gnt0), 32'd1);
      step();
      chk("w0_rdy_done", 32'(rdy0), 32'd0);
      chk("w0_gnt_idle", 32'(gnt0), 32'd0);
      req0 = 1'b1;
      step();
      start0 = 1'b1; mode0 = 2'b00; addr0 = 8'h05;
      step();
      start0 = 1'b0;
      chk("w0_rd_rdy", 32'(rdy0), 32'd1);
      chk("w0_rd_data", 32'(rdata0), 32'h3C);

      // Main instance: get the bus and fill the whole array.
      req = 1'b1;
      step();
      chk("first_gnt", 32'(gnt), 32'd1);
      for (int i = 0; i < 256; i++) xfer(2'b01, 8'(i), 8'($urandom));

      xfer(2'b01, 8'h10, 8'hA5);
      xfer(2'b00, 8'h10, 8'h00);
      chk("wr_rd_a5", 32'(rdata), 32'hA5);
      xfer(2'b11, 8'h10, 8'h77);
      chk("rsvd_hold", 32'(rdata), 32'hA5);
      xfer(2'b00, 8'h10, 8'h00);
      chk("rsvd_nowrite", 32'(rdata), 32'hA5);

      xfer(2'b01, 8'hFE, 8'h11);
      xfer(2'b01, 8'hFF, 8'h22);
      xfer(2'b01, 8'h00, 8'h33);
      xfer(2'b01, 8'h01, 8'h44);
      xfer(2'b10, 8'hFE, 8'h00);
      chk("burst_last", 32'(rdata), (BURST_BEATS == 4) ? 32'h44 : 32'h11);

      // Reset during the wait state of a write.
      xfer(2'b01, 8'h20, 8'h5A);
      start = 1'b1; mode = 2'b01; addr = 8'h20; wdata = 8'hC3; req = 1'b1;
      step();
      start = 1'b0;
      rst = 1'b1;
      #1;
      chk("midrst_gnt", 32'(gnt), 32'd0);
      chk("midrst_rdy", 32'(rdy), 32'd0);
      chk("midrst_rdata", 32'(rdata), 32'd0);
      @(negedge clk);
      req = 1'b0; rst = 1'b0; rd_m = 8'h00;
      step();
      chk("postrst_gnt", 32'(gnt), 32'd0);
      req = 1'b1;
      step();
      chk("postrst_regrant", 32'(gnt), 32'd1);
      xfer(2'b00, 8'h20, 8'h00);
      chk("rst_no_write", 32'(rdata), 32'h5A);

      // Random traffic.
      for (int t = 0; t < 300; t++) begin
         if ($urandom_range(0, 7) == 0) idle_gap();
         xfer(2'($urandom), 8'($urandom), 8'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
